pid_loop_sequencer: RTL and testbench
=====================================

// Module: pid_loop_sequencer
// PURPOSE
//  Schedules one PID control iteration per sample period and owns the shared external SPI master bus (ctrl_*).
//  Per tick: read one sample from the ADC (ctrl_in_cs), hand it to the PID datapath, await its result,
//  then write the result to the DAC (ctrl_out_cs).
//  The two chip selects are mutually exclusive by construction.
//  Sits between the config/SPI-slave block (supplies en, period) and the PID arithmetic core.
// PARAMETERS
//  DATA_W      8   sample / actuator word width, SPI frame length in bits
//  PERIOD_W    16  width of period input and tick counter
//  CLK_DIV     2   clk cycles per ctrl_clk half-period (>=1)
//  PID_TIMEOUT 64  max clk cycles from pid_start to pid_done before abort
// PORTS
//  clk          in   1         system clock, rising edge
//  reset        in   1         asynchronous, active-low (0 = in reset)
//  en           in   1         loop enable
//  period       in   PERIOD_W  tick interval in clk cycles minus 1; 0 = no ticks
//  pv           out  DATA_W    last sampled process value
//  pv_valid     out  1         one-cycle pulse, pv updated
//  pid_start    out  1         one-cycle pulse, PID may consume pv
//  pid_done     in   1         PID result valid (sampled while in COMPUTE)
//  pid_out      in   DATA_W    PID result, captured on pid_done
//  ctrl_clk     out  1         SPI SCLK, mode 0 (idle low)
//  ctrl_mosi    out  1         SPI MOSI, MSB first
//  ctrl_in_cs   out  1         ADC chip select, active-low
//  ctrl_out_cs  out  1         DAC chip select, active-low
//  ctrl_miso    in   1         SPI MISO from ADC
//  busy         out  1         high in any state but IDLE
//  status       out  2         sticky {timeout, overrun}; cleared while en=0
// BEHAVIOUR
//  Reset: ctrl_clk=0, ctrl_mosi=0, both CS=1, pv=0, pv_valid=0, pid_start=0, busy=0, status=0,
//  tick counter=0, state=IDLE. Asynchronous: CS deassert immediately, mid-frame included.
//  Tick counter: runs only while en=1 and period!=0.
//   Counts 0..period; tick fires for one cycle when count==period, then count returns to 0.
//   en=0 holds count at 0. Tick interval = period+1 cycles.
//  FSM: IDLE -> READ -> COMPUTE -> WRITE -> IDLE.
//   IDLE: on tick && en -> READ. Any tick outside IDLE is dropped and sets status[0].
//   READ: one SPI frame on ctrl_in_cs, ctrl_mosi held 0. Frame end: pv <= shifted word, pv_valid=1.
//   COMPUTE: entered the cycle after READ frame end; pid_start=1 on its first cycle only.
//    pid_done seen -> latch pid_out, -> WRITE.
//    PID_TIMEOUT cycles without pid_done -> status[1]=1, -> IDLE, no DAC write.
//    pid_done outside COMPUTE is ignored.
//   WRITE: one SPI frame on ctrl_out_cs, shifting latched pid_out MSB first; then -> IDLE.
//  en=0 outside IDLE: the in-flight iteration completes; no new tick is accepted.
//  SPI frame, in half-periods h of CLK_DIV clk each (total (2*DATA_W+2)*CLK_DIV cycles):
//   h=0: CS low, SCLK low, MOSI = bit DATA_W-1.
//   odd h (1..2*DATA_W-1): SCLK high; MISO sampled on entry.
//   even h (2..2*DATA_W): SCLK low; MOSI shifts to next bit.
//   h=2*DATA_W+1: SCLK low, CS held low. CS rises at frame end.
//   CS is high for >=1 cycle between READ and WRITE frames (COMPUTE lasts >=1 cycle).
//  Frames are never truncated except by reset. ctrl_clk toggles only while a CS is low.
// STRUCTURE
//  pid_defs.vh: FSM state encodings (IDLE/READ/COMPUTE/WRITE) and status bit indices, shared with config regmap.
//  Sub-module spi_frame_engine (start, tx_word, rx_word, done; CLK_DIV/DATA_W params):
//   one instance, time-shared by READ and WRITE; the sequencer steers CS by state.
// TESTING (DATA_W=8, CLK_DIV=2, PID_TIMEOUT=64)
//  1. reset=0 mid-sim -> all outputs at reset values in the same timestep; release + en=1, period=99
//     -> first ctrl_in_cs fall 100 cycles later.
//  2. ADC model returns 0xA5; PID model asserts pid_done 3 cycles after pid_start with 0x3C
//     -> read frame 36 cycles, 8 SCLK rises, pv=0xA5 + one pv_valid pulse, DAC receives 0x3C, status=0.
//  3. period=19 (shorter than one iteration) -> status[0] set, frames never overlap, CS never both low.
//  4. pid_done held 0 -> status[1] set 64 cycles after pid_start, ctrl_out_cs stays high, busy falls.
//  5. en 1->0 during READ frame -> frame and rest of iteration complete; no further frames;
//     status cleared; counter held at 0.
//  6. reset=0 during WRITE frame, bit 4 -> ctrl_out_cs=1 and ctrl_clk=0 asynchronously;
//     no partial frame resumes after release.

Source files
------------

// File: rtl/pid_loop_sequencer_pkg.sv
// Shared definitions for the PID loop sequencer: FSM state encoding and status bit positions.
package pid_loop_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_READ    = 2'd1,
        S_COMPUTE = 2'd2,
        S_WRITE   = 2'd3
    } state_e;

    localparam int ST_OVERRUN = 0;
    localparam int ST_TIMEOUT = 1;

endpackage

// File: rtl/pid_loop_sequencer_spi.sv
// SPI mode-0 frame engine: one DATA_W-bit full-duplex frame per start, MSB first.
// Frame is 2*DATA_W+2 half-periods of CLK_DIV clk; done is high on the frame's last cycle.
module pid_loop_sequencer_spi #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_word,
    input  logic              miso,
    output logic [DATA_W-1:0] rx_word,
    output logic              done,
    output logic              active,
    output logic              sclk,
    output logic              mosi
);

    localparam int H_LAST = 2 * DATA_W + 1;
    localparam int H_W    = $clog2(H_LAST + 1);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic              active_q, active_d;
    logic [H_W-1:0]    h_q, h_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;

    logic              half_end;
    logic              last_half;
    logic [H_W-1:0]    h_nxt;

    assign half_end  = active_q && (div_q == DIV_W'(CLK_DIV - 1));
    assign last_half = (h_q == H_W'(H_LAST));
    assign h_nxt     = h_q + 1'b1;
    assign done      = half_end && last_half;

    always_comb begin
        active_d = active_q;
        h_d      = h_q;
        div_d    = div_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        if (!active_q) begin
            if (start) begin
                active_d = 1'b1;
                h_d      = '0;
                div_d    = '0;
                tx_d     = tx_word;
                mosi_d   = tx_word[DATA_W-1];
                sclk_d   = 1'b0;
            end
        end else if (!half_end) begin
            div_d = div_q + 1'b1;
        end else if (last_half) begin
            active_d = 1'b0;
            div_d    = '0;
            sclk_d   = 1'b0;
            mosi_d   = 1'b0;
        end else begin
            div_d = '0;
            h_d   = h_nxt;
            // Odd half-periods raise SCLK and sample MISO, except the trailing CS-hold half.
            if (h_nxt[0]) begin
                if (h_nxt != H_W'(H_LAST)) begin
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[DATA_W-2:0], miso};
                end
            end else begin
                sclk_d = 1'b0;
                tx_d   = tx_q << 1;
                mosi_d = tx_q[DATA_W-2];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q <= 1'b0;
            h_q      <= '0;
            div_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            h_q      <= h_d;
            div_q    <= div_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
        end
    end

    assign rx_word = rx_q;
    assign active  = active_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;

endmodule

// File: rtl/pid_loop_sequencer.sv
// Per sample tick: read the ADC over SPI, hand the sample to the PID core, then write its
// result to the DAC over the same SPI bus. Chip selects are steered by FSM state.
module pid_loop_sequencer
    import pid_loop_sequencer_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int PERIOD_W    = 16,
    parameter int CLK_DIV     = 2,
    parameter int PID_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period,
    output logic [DATA_W-1:0]   pv,
    output logic                pv_valid,
    output logic                pid_start,
    input  logic                pid_done,
    input  logic [DATA_W-1:0]   pid_out,
    output logic                ctrl_clk,
    output logic                ctrl_mosi,
    output logic                ctrl_in_cs,
    output logic                ctrl_out_cs,
    input  logic                ctrl_miso,
    output logic                busy,
    output logic [1:0]          status,
    output logic [1:0]          state_dbg
);

    localparam int TMO_W = $clog2(PID_TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] count_q, count_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [DATA_W-1:0]   pv_q, pv_d;
    logic                pv_valid_q, pv_valid_d;
    logic                pid_start_q, pid_start_d;
    logic [1:0]          status_q, status_d;

    logic                run;
    logic                tick;
    logic                eng_start;
    logic [DATA_W-1:0]   eng_tx;
    logic [DATA_W-1:0]   eng_rx;
    logic                eng_done;
    logic                eng_active;

    // >= rather than == so a period lowered on the fly cannot strand the counter.
    assign run  = en && (period != '0);
    assign tick = run && (count_q >= period);

    always_comb begin
        state_d     = state_q;
        count_d     = (run && !tick) ? count_q + 1'b1 : '0;
        tmo_d       = tmo_q;
        pv_d        = pv_q;
        pv_valid_d  = 1'b0;
        pid_start_d = 1'b0;
        status_d    = status_q;
        eng_start   = 1'b0;
        eng_tx      = '0;
        if (tick && state_q != S_IDLE) begin
            status_d[ST_OVERRUN] = 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d   = S_READ;
                    eng_start = 1'b1;
                end
            end
            S_READ: begin
                if (eng_done) begin
                    state_d     = S_COMPUTE;
                    pv_d        = eng_rx;
                    pv_valid_d  = 1'b1;
                    pid_start_d = 1'b1;
                    tmo_d       = '0;
                end
            end
            S_COMPUTE: begin
                if (pid_done) begin
                    state_d   = S_WRITE;
                    eng_start = 1'b1;
                    eng_tx    = pid_out;
                end else if (tmo_q == TMO_W'(PID_TIMEOUT - 1)) begin
                    state_d               = S_IDLE;
                    status_d[ST_TIMEOUT]  = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WRITE: begin
                if (eng_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (!en) begin
            status_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            tmo_q       <= '0;
            pv_q        <= '0;
            pv_valid_q  <= 1'b0;
            pid_start_q <= 1'b0;
            status_q    <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            tmo_q       <= tmo_d;
            pv_q        <= pv_d;
            pv_valid_q  <= pv_valid_d;
            pid_start_q <= pid_start_d;
            status_q    <= status_d;
        end
    end

    pid_loop_sequencer_spi #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) u_spi (
        .clk     (clk),
        .reset   (reset),
        .start   (eng_start),
        .tx_word (eng_tx),
        .miso    (ctrl_miso),
        .rx_word (eng_rx),
        .done    (eng_done),
        .active  (eng_active),
        .sclk    (ctrl_clk),
        .mosi    (ctrl_mosi)
    );

    // Only one state can own the engine, so the two selects never overlap.
    assign ctrl_in_cs  = ~(eng_active && (state_q == S_READ));
    assign ctrl_out_cs = ~(eng_active && (state_q == S_WRITE));

    assign pv        = pv_q;
    assign pv_valid  = pv_valid_q;
    assign pid_start = pid_start_q;
    assign busy      = (state_q != S_IDLE);
    assign status    = status_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pid_loop_sequencer.sv
// Bench for pid_loop_sequencer: ADC/PID/DAC models feed scoreboards checked by one monitor process.
module tb_pid_loop_sequencer;

  localparam int DATA_W      = 8;
  localparam int PERIOD_W    = 16;
  localparam int CLK_DIV     = 2;
  localparam int PID_TIMEOUT = 64;
  localparam int FRAME_CYC   = (2 * DATA_W + 2) * CLK_DIV;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic                en;
  logic [PERIOD_W-1:0] period;
  logic [DATA_W-1:0]   pv;
  logic                pv_valid;
  logic                pid_start;
  logic                pid_done;
  logic [DATA_W-1:0]   pid_out;
  logic                ctrl_clk;
  logic                ctrl_mosi;
  logic                ctrl_in_cs;
  logic                ctrl_out_cs;
  logic                ctrl_miso;
  logic                busy;
  logic [1:0]          status;
  logic [1:0]          state_dbg;

  pid_loop_sequencer #(
    .DATA_W      (DATA_W),
    .PERIOD_W    (PERIOD_W),
    .CLK_DIV     (CLK_DIV),
    .PID_TIMEOUT (PID_TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .period      (period),
    .pv          (pv),
    .pv_valid    (pv_valid),
    .pid_start   (pid_start),
    .pid_done    (pid_done),
    .pid_out     (pid_out),
    .ctrl_clk    (ctrl_clk),
    .ctrl_mosi   (ctrl_mosi),
    .ctrl_in_cs  (ctrl_in_cs),
    .ctrl_out_cs (ctrl_out_cs),
    .ctrl_miso   (ctrl_miso),
    .busy        (busy),
    .status      (status),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int check_cnt = 0;
  int pass_cnt  = 0;
  logic [DATA_W-1:0] exp_pv_q[$];
  logic [DATA_W-1:0] exp_dac_q[$];

  logic pid_hang     = 1'b0;
  int   exp_interval = 0;

  int in_falls    = 0;
  int out_falls   = 0;
  int dac_frames  = 0;
  int dac_rises   = 0;
  bit overlap_seen     = 1'b0;
  bit idle_sclk_seen   = 1'b0;
  bit pv_valid_double  = 1'b0;
  bit pid_start_double = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor + ADC slave + DAC receiver ----------------
  initial begin
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] adc_sh;
    logic [DATA_W-1:0] dac_sh;
    logic [DATA_W-1:0] exp_w;
    logic prev_in_cs, prev_out_cs, prev_sclk, prev_reset, prev_pv_valid, prev_pid_start;
    int   cyc, adc_frames, in_len, in_rises, out_len, last_fall_cyc, last_fall_exp;
    ctrl_miso = 1'b0;
    prev_in_cs = 1'b1; prev_out_cs = 1'b1; prev_sclk = 1'b0; prev_reset = 1'b0;
    prev_pv_valid = 1'b0; prev_pid_start = 1'b0;
    cyc = 0; adc_frames = 0; in_len = 0; in_rises = 0; out_len = 0;
    last_fall_cyc = 0; last_fall_exp = 0;
    adc_sh = '0; dac_sh = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!ctrl_in_cs && !ctrl_out_cs) overlap_seen = 1'b1;
      if (reset && prev_reset && ctrl_in_cs && ctrl_out_cs && (ctrl_clk != prev_sclk))
        idle_sclk_seen = 1'b1;

      // ADC: new random sample per frame, shifted out on SCLK falling edges
      if (!ctrl_in_cs && prev_in_cs) begin
        in_falls++;
        word = (adc_frames == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
        adc_frames++;
        adc_sh = word;
        ctrl_miso = word[DATA_W-1];
        exp_pv_q.push_back(word);
        in_len = 0;
        in_rises = 0;
        if (exp_interval != 0 && last_fall_exp == exp_interval)
          check("tick_interval", cyc - last_fall_cyc, exp_interval);
        last_fall_cyc = cyc;
        last_fall_exp = exp_interval;
      end else if (!ctrl_in_cs && prev_sclk && !ctrl_clk) begin
        adc_sh = adc_sh << 1;
        ctrl_miso = adc_sh[DATA_W-1];
      end
      if (!ctrl_in_cs) begin
        in_len++;
        if (ctrl_clk && !prev_sclk) in_rises++;
      end
      if (ctrl_in_cs && !prev_in_cs) begin
        if (reset) begin
          check("read_frame_len", in_len, FRAME_CYC);
          check("read_sclk_rises", in_rises, DATA_W);
        end
        ctrl_miso = 1'b0;
      end

      // DAC: capture MOSI on SCLK rising edges
      if (!ctrl_out_cs && prev_out_cs) begin
        out_falls++;
        out_len = 0;
        dac_rises = 0;
        dac_sh = '0;
      end
      if (!ctrl_out_cs) begin
        out_len++;
        if (ctrl_clk && !prev_sclk) begin
          dac_rises++;
          dac_sh = {dac_sh[DATA_W-2:0], ctrl_mosi};
        end
      end
      if (ctrl_out_cs && !prev_out_cs) begin
        if (exp_dac_q.size() == 0) begin
          check("dac_queue_depth", exp_dac_q.size(), 1);
        end else begin
          exp_w = exp_dac_q.pop_front();
          if (reset) begin
            dac_frames++;
            check("dac_word", dac_sh, exp_w);
            check("write_frame_len", out_len, FRAME_CYC);
            check("write_sclk_rises", dac_rises, DATA_W);
          end
        end
      end

      // process-value scoreboard
      if (pv_valid) begin
        if (prev_pv_valid) pv_valid_double = 1'b1;
        check("pid_start_with_pv", pid_start, 1);
        if (exp_pv_q.size() == 0) check("pv_queue_depth", exp_pv_q.size(), 1);
        else check("pv_word", pv, exp_pv_q.pop_front());
      end
      if (pid_start && prev_pid_start) pid_start_double = 1'b1;

      prev_in_cs     = ctrl_in_cs;
      prev_out_cs    = ctrl_out_cs;
      prev_sclk      = ctrl_clk;
      prev_reset     = reset;
      prev_pv_valid  = pv_valid;
      prev_pid_start = pid_start;
    end
  end

  // ---------------- PID core model ----------------
  initial begin
    int d;
    int resp;
    logic [DATA_W-1:0] v;
    pid_done = 1'b0;
    pid_out  = '0;
    resp = 0;
    forever begin
      @(posedge clk);
      #1;
      if (pid_start && !pid_hang) begin
        if (resp == 0) begin
          d = 3;
          v = 8'h3C;
        end else begin
          d = $urandom_range(1, 10);
          v = 8'($urandom_range(0, 255));
        end
        resp++;
        repeat (d) @(posedge clk);
        #1;
        pid_done = 1'b1;
        pid_out  = v;
        exp_dac_q.push_back(v);
        @(posedge clk);
        #1;
        pid_done = 1'b0;
        // stray result during WRITE must not disturb the DAC frame
        if ($urandom_range(0, 1) == 1) begin
          repeat (4) @(posedge clk);
          #1;
          pid_done = 1'b1;
          pid_out  = ~v;
          @(posedge clk);
          #1;
          pid_done = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic measure_first_tick(input int p);
    int n;
    @(negedge clk);
    period = PERIOD_W'(p);
    en = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (ctrl_in_cs && n < 3000);
    check("first_tick_delay", n, p + 1);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("busy_falls", busy, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, d0, in0, out0;
    reset = 1'b0;
    en = 1'b0;
    period = '0;

    repeat (3) @(negedge clk);
    check("rst_in_cs", ctrl_in_cs, 1);
    check("rst_out_cs", ctrl_out_cs, 1);
    check("rst_sclk", ctrl_clk, 0);
    check("rst_mosi", ctrl_mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_status", status, 0);
    check("rst_pv", pv, 0);
    @(negedge clk);
    reset = 1'b1;

    // first tick latency, fixed 0xA5 / 0x3C iteration, then random iterations
    exp_interval = 100;
    measure_first_tick(99);
    n = 0;
    while (dac_frames < 6 && n < 1500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("iterations_done", (dac_frames >= 6) ? 1 : 0, 1);
    check("status_clean_run", status, 0);
    @(negedge clk);
    exp_interval = 0;
    en = 1'b0;
    wait_idle(200);

    // period shorter than one iteration
    measure_first_tick(19);
    repeat (400) @(posedge clk);
    #1;
    check("overrun_set", status, 2'b01);
    @(negedge clk);
    en = 1'b0;
    wait_idle(200);
    repeat (2) @(posedge clk);
    #1;
    check("status_cleared_en0", status, 0);

    // enable dropped mid READ frame: iteration finishes, then silence
    measure_first_tick(149);
    repeat (10) @(negedge clk);
    en = 1'b0;
    d0 = dac_frames;
    wait_idle(300);
    check("iteration_completes", dac_frames, d0 + 1);
    in0 = in_falls;
    repeat (300) @(posedge clk);
    #1;
    check("no_frames_en0", in_falls, in0);
    check("status_en0", status, 0);

    // PID never answers
    @(negedge clk);
    pid_hang = 1'b1;
    out0 = out_falls;
    measure_first_tick(199);
    n = 0;
    while (!pid_start && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("pid_start_seen", pid_start, 1);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!status[1] && n < 200);
    check("timeout_cycles", n, PID_TIMEOUT);
    check("busy_after_timeout", busy, 0);
    repeat (20) @(posedge clk);
    #1;
    check("timeout_sticky", status, 2'b10);
    check("no_dac_on_timeout", out_falls, out0);
    @(negedge clk);
    en = 1'b0;
    pid_hang = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("timeout_cleared", status, 0);

    // asynchronous reset in the middle of a WRITE frame
    measure_first_tick(149);
    n = 0;
    while (ctrl_out_cs && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("write_frame_started", ctrl_out_cs, 0);
    n = 0;
    while (dac_rises < 4 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    #2;
    reset = 1'b0;
    #1;
    check("async_out_cs", ctrl_out_cs, 1);
    check("async_sclk", ctrl_clk, 0);
    check("async_mosi", ctrl_mosi, 0);
    check("async_busy", busy, 0);
    check("async_pv", pv, 0);
    en = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    in0 = in_falls;
    out0 = out_falls;
    repeat (100) @(posedge clk);
    #1;
    check("no_resume_in", in_falls, in0);
    check("no_resume_out", out_falls, out0);

    // one clean iteration after recovery
    d0 = dac_frames;
    measure_first_tick(59);
    n = 0;
    while (dac_frames == d0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("post_reset_iteration", dac_frames, d0 + 1);
    @(negedge clk);
    en = 1'b0;
    wait_idle(200);
    repeat (5) @(posedge clk);
    #1;

    check("cs_never_both_low", overlap_seen, 0);
    check("sclk_quiet_when_deselected", idle_sclk_seen, 0);
    check("pv_valid_single_pulse", pv_valid_double, 0);
    check("pid_start_single_pulse", pid_start_double, 0);
    check("pv_queue_drained", exp_pv_q.size(), 0);
    check("dac_queue_drained", exp_dac_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", pass_cnt, check_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule
